// File: rtl/reg_file_mp.sv
// Multi-port register file with same-cycle write-to-read bypass and a per-register
// pending scoreboard used by decode for operand hazard checks.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*$clog2(NREGS)-1:0] waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD*$clog2(NREGS)-1:0] raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                sb_set,
    input  logic [$clog2(NREGS)-1:0] sb_addr,
    output logic                wr_conflict
);

    localparam int AW = $clog2(NREGS);
    // One extra bit so NREGS itself is representable when it is a power of two.
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [XLEN-1:0]  regs_reg [NREGS];
    logic [NREGS-1:0] pending_reg;
    logic             wr_conflict_reg;
    logic             wr_conflict_next;

    logic [NWR-1:0]   wr_eff;
    logic [AW-1:0]    wa [NWR];
    logic [XLEN-1:0]  wd [NWR];
    logic             sb_eff;

    // A write port is effective only for an in-range, writable register.
    generate
        for (genvar gi = 0; gi < NWR; gi++) begin : g_wport
            assign wa[gi] = waddr[gi*AW +: AW];
            assign wd[gi] = wdata[gi*XLEN +: XLEN];
            assign wr_eff[gi] = we[gi]
                              && ({1'b0, wa[gi]} < NREGS_W)
                              && !((ZERO_REG != 0) && (wa[gi] == '0));
        end
    endgenerate

    assign sb_eff = sb_set
                  && ({1'b0, sb_addr} < NREGS_W)
                  && !((ZERO_REG != 0) && (sb_addr == '0));

    always_comb begin
        wr_conflict_next = 1'b0;
        for (int a = 0; a < NWR; a++) begin
            for (int b = a + 1; b < NWR; b++) begin
                if (wr_eff[a] && wr_eff[b] && (wa[a] == wa[b])) begin
                    wr_conflict_next = 1'b1;
                end
            end
        end
    end

    // Ports are visited in ascending order so the highest-index writer lands last;
    // a same-cycle issue re-arms pending after the completing write clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_reg[r] <= '0;
            end
            pending_reg     <= '0;
            wr_conflict_reg <= 1'b0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_eff[j]) begin
                    regs_reg[wa[j]]    <= wd[j];
                    pending_reg[wa[j]] <= 1'b0;
                end
            end
            if (sb_eff) begin
                pending_reg[sb_addr] <= 1'b1;
            end
            wr_conflict_reg <= wr_conflict_next;
        end
    end

    assign wr_conflict = wr_conflict_reg;

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rport
            logic [AW-1:0]   ra;
            logic            ra_ok;
            logic            hit;
            logic [XLEN-1:0] hit_data;

            assign ra    = raddr[gi*AW +: AW];
            assign ra_ok = ({1'b0, ra} < NREGS_W)
                         && !((ZERO_REG != 0) && (ra == '0));

            always_comb begin
                hit      = 1'b0;
                hit_data = '0;
                for (int j = 0; j < NWR; j++) begin
                    if ((BYPASS != 0) && wr_eff[j] && (wa[j] == ra)) begin
                        hit      = 1'b1;
                        hit_data = wd[j];
                    end
                end
            end

            assign rdata[gi*XLEN +: XLEN] = !ra_ok ? '0 :
                                            hit    ? hit_data : regs_reg[ra];
            // A forwarded result satisfies the consumer, so it is not busy.
            assign rbusy[gi] = ra_ok && pending_reg[ra] && !hit;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed checks on default 2R/2W instances (bypass on/off),
// then random traffic on 4R/3W instances with 16 and 12 registers against a model.
module tb_reg_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Directed instances: 32 regs, 2R/2W.
    logic        reset;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [9:0]  raddr;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [63:0] rd_a, rd_b;
    logic [1:0]  rb_a, rb_b;
    logic        wc_a, wc_b;

    reg_file_mp #(.BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rd_a), .rbusy(rb_a), .sb_set(sb_set),
        .sb_addr(sb_addr), .wr_conflict(wc_a)
    );
    reg_file_mp #(.BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rd_b), .rbusy(rb_b), .sb_set(sb_set),
        .sb_addr(sb_addr), .wr_conflict(wc_b)
    );

    // Random instances: 4R/3W, 16 and 12 registers share one 4-bit address stimulus.
    logic         rreset;
    logic [2:0]   r_we;
    logic [11:0]  r_waddr;
    logic [95:0]  r_wdata;
    logic [15:0]  r_raddr;
    logic         r_sb_set;
    logic [3:0]   r_sb_addr;
    logic [127:0] rd16, rd12;
    logic [3:0]   rb16, rb12;
    logic         wc16, wc12;
    logic         rnd_active;

    reg_file_mp #(.NREGS(16), .NRD(4), .NWR(3)) dut_r16 (
        .clk(clk), .reset(rreset), .we(r_we), .waddr(r_waddr), .wdata(r_wdata),
        .raddr(r_raddr), .rdata(rd16), .rbusy(rb16), .sb_set(r_sb_set),
        .sb_addr(r_sb_addr), .wr_conflict(wc16)
    );
    reg_file_mp #(.NREGS(12), .NRD(4), .NWR(3)) dut_r12 (
        .clk(clk), .reset(rreset), .we(r_we), .waddr(r_waddr), .wdata(r_wdata),
        .raddr(r_raddr), .rdata(rd12), .rbusy(rb12), .sb_set(r_sb_set),
        .sb_addr(r_sb_addr), .wr_conflict(wc12)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model for the random instances ----------------
    bit [31:0] m_regs [2][16];
    bit        m_pend [2][16];
    bit        m_conf [2];

    function automatic int nr(input int k);
        return (k == 0) ? 16 : 12;
    endfunction

    function automatic bit valid(input int k, input logic [3:0] a);
        return (int'(a) < nr(k)) && (a != 4'd0);
    endfunction

    function automatic bit weff(input int k, input int j);
        return r_we[j] && valid(k, r_waddr[j*4 +: 4]);
    endfunction

    function automatic logic [31:0] exp_rd(input int k, input int i);
        logic [3:0]  a;
        logic [31:0] v;
        a = r_raddr[i*4 +: 4];
        if (!valid(k, a)) return 32'd0;
        v = m_regs[k][a];
        for (int j = 0; j < 3; j++)
            if (weff(k, j) && r_waddr[j*4 +: 4] == a) v = r_wdata[j*32 +: 32];
        return v;
    endfunction

    function automatic logic exp_busy(input int k, input int i);
        logic [3:0] a;
        logic       b;
        a = r_raddr[i*4 +: 4];
        if (!valid(k, a)) return 1'b0;
        b = m_pend[k][a];
        for (int j = 0; j < 3; j++)
            if (weff(k, j) && r_waddr[j*4 +: 4] == a) b = 1'b0;
        return b;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rreset) begin
                    for (int r = 0; r < 16; r++) begin
                        m_regs[k][r] = 32'd0;
                        m_pend[k][r] = 1'b0;
                    end
                    m_conf[k] = 1'b0;
                end else begin
                    m_conf[k] = 1'b0;
                    for (int a = 0; a < 3; a++)
                        for (int b = a + 1; b < 3; b++)
                            if (weff(k, a) && weff(k, b) &&
                                r_waddr[a*4 +: 4] == r_waddr[b*4 +: 4]) m_conf[k] = 1'b1;
                    for (int j = 0; j < 3; j++) begin
                        if (weff(k, j)) begin
                            m_regs[k][r_waddr[j*4 +: 4]] = r_wdata[j*32 +: 32];
                            m_pend[k][r_waddr[j*4 +: 4]] = 1'b0;
                        end
                    end
                    if (r_sb_set && valid(k, r_sb_addr)) m_pend[k][r_sb_addr] = 1'b1;
                end
            end
        end
    end

    // Compare process: inputs change at posedge+2, outputs are sampled at negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rnd_active) begin
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("r16 rdata%0d", i), rd16[i*32 +: 32], exp_rd(0, i));
                    chk($sformatf("r12 rdata%0d", i), rd12[i*32 +: 32], exp_rd(1, i));
                    chk($sformatf("r16 rbusy%0d", i), 32'(rb16[i]), 32'(exp_busy(0, i)));
                    chk($sformatf("r12 rbusy%0d", i), 32'(rb12[i]), 32'(exp_busy(1, i)));
                end
                chk("r16 wr_conflict", 32'(wc16), 32'(m_conf[0]));
                chk("r12 wr_conflict", 32'(wc12), 32'(m_conf[1]));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we     = 2'b00;
        sb_set = 1'b0;
    endtask

    task automatic wr(input int j, input logic [4:0] a, input logic [31:0] d);
        we[j]              = 1'b1;
        waddr[j*5 +: 5]    = a;
        wdata[j*32 +: 32]  = d;
    endtask

    task automatic rd(input int i, input logic [4:0] a);
        raddr[i*5 +: 5] = a;
    endtask

    function automatic logic [31:0] rda(input int i);
        return rd_a[i*32 +: 32];
    endfunction

    function automatic logic [31:0] rdb(input int i);
        return rd_b[i*32 +: 32];
    endfunction

    task automatic rand_addr(output logic [3:0] a);
        if ($urandom_range(0, 3) == 0) a = 4'($urandom_range(0, 2));
        else                           a = 4'($urandom_range(0, 15));
    endtask

    initial begin
        reset = 1'b1; rreset = 1'b1; rnd_active = 1'b0;
        we = '0; waddr = '0; wdata = '0; raddr = '0; sb_set = 1'b0; sb_addr = '0;
        r_we = '0; r_waddr = '0; r_wdata = '0; r_raddr = '0; r_sb_set = 1'b0; r_sb_addr = '0;
        tick(); tick();
        reset = 1'b0;

        // T1: prefill, then a reset cycle with colliding writes and an issue.
        wr(0, 5'd3, 32'h33); wr(1, 5'd4, 32'h44); sb_set = 1'b1; sb_addr = 5'd3;
        tick(); idle(); rd(0, 5'd3); rd(1, 5'd4); #1;
        chk("T1 prefill r3", rda(0), 32'h33);
        chk("T1 prefill r4", rdb(1), 32'h44);
        chk("T1 prefill busy r3", 32'(rb_a[0]), 32'd1);
        reset = 1'b1; wr(0, 5'd6, 32'h66); wr(1, 5'd6, 32'h77); sb_set = 1'b1; sb_addr = 5'd6;
        tick(); reset = 1'b0; idle(); rd(0, 5'd3); rd(1, 5'd6); #1;
        chk("T1 a rdata0", rda(0), 32'd0);
        chk("T1 a rdata1", rda(1), 32'd0);
        chk("T1 b rdata0", rdb(0), 32'd0);
        chk("T1 b rdata1", rdb(1), 32'd0);
        chk("T1 a rbusy", 32'(rb_a), 32'd0);
        chk("T1 b rbusy", 32'(rb_b), 32'd0);
        chk("T1 a wr_conflict", 32'(wc_a), 32'd0);
        chk("T1 b wr_conflict", 32'(wc_b), 32'd0);
        $display("T1 reset: done");

        // T2: zero register ignores writes and issues.
        wr(0, 5'd0, 32'hDEAD_BEEF); sb_set = 1'b1; sb_addr = 5'd0; rd(0, 5'd0); rd(1, 5'd0); #1;
        chk("T2 same-cycle a rdata", rda(0), 32'd0);
        chk("T2 same-cycle b rdata", rdb(0), 32'd0);
        chk("T2 same-cycle a rbusy", 32'(rb_a[0]), 32'd0);
        tick(); idle(); #1;
        chk("T2 next a rdata", rda(0), 32'd0);
        chk("T2 next b rdata", rdb(1), 32'd0);
        chk("T2 next a rbusy", 32'(rb_a[0]), 32'd0);
        chk("T2 next b rbusy", 32'(rb_b[1]), 32'd0);
        $display("T2 zero register: done");

        // T3: bypass vs. registered visibility.
        wr(0, 5'd5, 32'h1111); tick(); idle();
        wr(0, 5'd5, 32'h1234); rd(0, 5'd5); #1;
        chk("T3 bypass same-cycle", rda(0), 32'h1234);
        chk("T3 no-bypass same-cycle", rdb(0), 32'h1111);
        tick(); idle(); #1;
        chk("T3 no-bypass next", rdb(0), 32'h1234);
        chk("T3 bypass next", rda(0), 32'h1234);
        $display("T3 bypass: done");

        // T4: same-address dual write, then distinct addresses.
        wr(0, 5'd7, 32'hA); wr(1, 5'd7, 32'hB); rd(0, 5'd7); #1;
        chk("T4 bypass highest port", rda(0), 32'hB);
        tick(); idle(); #1;
        chk("T4 a r7", rda(0), 32'hB);
        chk("T4 b r7", rdb(0), 32'hB);
        chk("T4 a wr_conflict", 32'(wc_a), 32'd1);
        chk("T4 b wr_conflict", 32'(wc_b), 32'd1);
        tick(); #1;
        chk("T4 a wr_conflict clears", 32'(wc_a), 32'd0);
        wr(0, 5'd10, 32'h10); wr(1, 5'd11, 32'h11); tick(); idle();
        rd(0, 5'd10); rd(1, 5'd11); #1;
        chk("T4 r10", rda(0), 32'h10);
        chk("T4 r11", rdb(1), 32'h11);
        chk("T4 distinct no conflict", 32'(wc_a), 32'd0);
        $display("T4 dual write: done");

        // T5: scoreboard set / clear / set-wins.
        sb_set = 1'b1; sb_addr = 5'd9; rd(0, 5'd9); #1;
        chk("T5 busy before set", 32'(rb_a[0]), 32'd0);
        tick(); idle(); #1;
        chk("T5 a busy after set", 32'(rb_a[0]), 32'd1);
        chk("T5 b busy after set", 32'(rb_b[0]), 32'd1);
        wr(0, 5'd9, 32'h99); #1;
        chk("T5 a busy in write cycle", 32'(rb_a[0]), 32'd0);
        chk("T5 b busy in write cycle", 32'(rb_b[0]), 32'd1);
        tick(); idle(); #1;
        chk("T5 a busy cleared", 32'(rb_a[0]), 32'd0);
        chk("T5 b busy cleared", 32'(rb_b[0]), 32'd0);
        chk("T5 r9 value", rda(0), 32'h99);
        sb_set = 1'b1; sb_addr = 5'd9; wr(1, 5'd9, 32'h98);
        tick(); idle(); #1;
        chk("T5 a set wins", 32'(rb_a[0]), 32'd1);
        chk("T5 b set wins", 32'(rb_b[0]), 32'd1);
        chk("T5 r9 rewritten", rdb(0), 32'h98);
        $display("T5 scoreboard: done");

        // T6: pin the model with a fixed vector, then random traffic.
        @(posedge clk); #2;
        rreset = 1'b0; rnd_active = 1'b1;
        r_we = 3'b001; r_waddr = 12'd13; r_wdata = 96'h5A; r_raddr = 16'd13;
        r_sb_set = 1'b1; r_sb_addr = 4'd13;
        @(negedge clk); #1;
        chk("T6 model r16 bypass", exp_rd(0, 0), 32'h5A);
        chk("T6 model r12 out-of-range", exp_rd(1, 0), 32'd0);
        chk("T6 r16 bypass", rd16[31:0], 32'h5A);
        chk("T6 r12 out-of-range", rd12[31:0], 32'd0);
        @(posedge clk); #2;
        r_we = 3'b000; r_sb_set = 1'b0; r_raddr = 16'h00D0;
        @(negedge clk); #1;
        chk("T6 model r16 busy", 32'(exp_busy(0, 1)), 32'd1);
        chk("T6 model r16 stored", m_regs[0][13], 32'h5A);
        chk("T6 r16 busy", 32'(rb16[1]), 32'd1);
        chk("T6 r12 busy out-of-range", 32'(rb12[1]), 32'd0);

        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #2;
            rreset = ($urandom_range(0, 999) == 0);
            for (int j = 0; j < 3; j++) begin
                logic [3:0] a;
                r_we[j] = 1'($urandom_range(0, 1));
                rand_addr(a);
                r_waddr[j*4 +: 4]  = a;
                r_wdata[j*32 +: 32] = $urandom;
            end
            for (int i = 0; i < 4; i++) begin
                logic [3:0] a;
                rand_addr(a);
                r_raddr[i*4 +: 4] = a;
            end
            r_sb_set  = ($urandom_range(0, 2) == 0);
            r_sb_addr = 4'($urandom_range(0, 15));
        end
        @(posedge clk); #6;
        rnd_active = 1'b0;
        $display("T6 random: done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
